// File: rtl/ex_result_stage.sv
// ex_result_stage: EX/MEM pipeline register sitting behind the shifter and the ALU.
// It selects the execute result, registers it with the instruction's control bits,
// and owns the Z/V/N flag register, the sticky halt state and the retired counter.
module ex_result_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovfl,
    input  logic [WIDTH-1:0] shift_out,
    input  logic [3:0]       dst_reg,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] store_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       out_dst_reg,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [WIDTH-1:0] out_store_data,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             halted,
    output logic [15:0]      retired
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic             accept_s;
    logic             is_shift_s;
    logic             is_hlt_s;
    logic             wr_zvn_s;
    logic             wr_z_s;
    logic [WIDTH-1:0] sel_result_s;
    logic             ctrl_pass_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       out_dst_reg_r;
    logic             out_reg_write_r;
    logic             out_mem_read_r;
    logic             out_mem_write_r;
    logic [WIDTH-1:0] out_store_data_r;
    logic             flag_z_r;
    logic             flag_v_r;
    logic             flag_n_r;
    logic             halted_r;
    logic [15:0]      retired_r;

    // Decode the opcode into result-select, flag-write and halt classes.
    always_comb begin
        is_shift_s = 1'b0;
        is_hlt_s   = 1'b0;
        wr_zvn_s   = 1'b0;
        wr_z_s     = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                wr_zvn_s = 1'b1;
            end
            OP_XOR: begin
                wr_z_s = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                is_shift_s = 1'b1;
                wr_z_s     = 1'b1;
            end
            OP_HLT: begin
                is_hlt_s = 1'b1;
            end
            default: begin
                is_shift_s = 1'b0;
            end
        endcase
    end

    // Select the execute result and work out whether the instruction is taken this cycle.
    always_comb begin
        accept_s = in_valid & ~stall & ~flush & ~halted_r;
        if (is_shift_s) begin
            sel_result_s = shift_out;
        end else begin
            sel_result_s = alu_out;
        end
        // HLT travels down the pipe as a live entry but must not write anything.
        if (accept_s && !is_hlt_s) begin
            ctrl_pass_s = 1'b1;
        end else begin
            ctrl_pass_s = 1'b0;
        end
    end

    // Stage register: reset > flush (bubble) > stall (hold) > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r      <= 1'b0;
            result_r         <= {WIDTH{1'b0}};
            out_dst_reg_r    <= 4'd0;
            out_reg_write_r  <= 1'b0;
            out_mem_read_r   <= 1'b0;
            out_mem_write_r  <= 1'b0;
            out_store_data_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            out_valid_r      <= 1'b0;
            out_reg_write_r  <= 1'b0;
            out_mem_read_r   <= 1'b0;
            out_mem_write_r  <= 1'b0;
        end else if (!stall) begin
            out_valid_r      <= accept_s;
            result_r         <= sel_result_s;
            out_dst_reg_r    <= dst_reg;
            out_store_data_r <= store_data;
            out_reg_write_r  <= reg_write & ctrl_pass_s;
            out_mem_read_r   <= mem_read  & ctrl_pass_s;
            out_mem_write_r  <= mem_write & ctrl_pass_s;
        end
    end

    // Architectural flags: only an accepted flag-writing instruction changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_r <= 1'b0;
            flag_v_r <= 1'b0;
            flag_n_r <= 1'b0;
        end else if (accept_s) begin
            if (wr_zvn_s || wr_z_s) begin
                flag_z_r <= (sel_result_s == {WIDTH{1'b0}});
            end
            if (wr_zvn_s) begin
                flag_v_r <= alu_ovfl;
                flag_n_r <= sel_result_s[WIDTH-1];
            end
        end
    end

    // Sticky halt and the retired-instruction counter (wraps naturally at 16 bits).
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r  <= 1'b0;
            retired_r <= 16'd0;
        end else if (accept_s) begin
            retired_r <= retired_r + 16'd1;
            if (is_hlt_s) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign out_valid      = out_valid_r;
    assign result         = result_r;
    assign out_dst_reg    = out_dst_reg_r;
    assign out_reg_write  = out_reg_write_r;
    assign out_mem_read   = out_mem_read_r;
    assign out_mem_write  = out_mem_write_r;
    assign out_store_data = out_store_data_r;
    assign flag_z         = flag_z_r;
    assign flag_v         = flag_v_r;
    assign flag_n         = flag_n_r;
    assign halted         = halted_r;
    assign retired        = retired_r;

endmodule
